// File: rtl/l1_mem_responder.sv
// rtl/l1_mem_responder.sv - single-outstanding line memory responder with fixed latency
// Reads burst one line as 64-bit beats; writes commit at handshake and return a single ack beat.
module l1_mem_responder #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned MEM_LINES  = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_req_valid,
    input  logic                      mem_req_rw,
    input  logic [31:0]               mem_req_addr,
    input  logic [LINE_BYTES*8-1:0]   mem_req_wdata,
    input  logic [LINE_BYTES/8-1:0]   mem_req_wstrb,
    input  logic [7:0]                mem_req_id,
    output logic                      mem_req_ready,
    output logic                      mem_resp_valid,
    output logic [63:0]               mem_resp_data,
    output logic [7:0]                mem_resp_id
);

    localparam int unsigned BEATS  = LINE_BYTES / 8;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(MEM_LINES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RD_BEATS,
        S_WR_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [31:0]         addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [7:0]          id_q, id_d;

    logic [MEM_LINES-1:0][BEATS-1:0] written_q;
    logic [63:0]                     mem_q [MEM_LINES][BEATS];

    logic             handshake;
    logic             wr_commit;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] line_idx;
    logic [63:0]      pattern;

    assign mem_req_ready = (state_q == S_IDLE);
    assign handshake     = mem_req_valid && mem_req_ready;
    assign wr_commit     = handshake && mem_req_rw;
    // Upper address bits above the index alias onto the same line.
    assign req_idx       = mem_req_addr[OFF_W +: IDX_W];
    assign line_idx      = addr_q[OFF_W +: IDX_W];
    assign pattern       = 64'hDEAD_BEEF_DEAD_BEEF ^ {32'h0, addr_q & ~32'h3F} ^ 64'(beat_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'(LATENCY - 1);
                    beat_d  = '0;
                    addr_d  = mem_req_addr;
                    rw_d    = mem_req_rw;
                    id_d    = mem_req_id;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = rw_q ? S_WR_ACK : S_RD_BEATS;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RD_BEATS: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_WR_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            id_q    <= id_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else if (wr_commit) begin
            for (int k = 0; k < int'(BEATS); k++) begin
                if (mem_req_wstrb[k]) begin
                    written_q[req_idx][k] <= 1'b1;
                end
            end
        end
    end

    // Line storage is deliberately not reset; the written flags decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int k = 0; k < int'(BEATS); k++) begin
                if (mem_req_wstrb[k]) begin
                    mem_q[req_idx][k] <= mem_req_wdata[k*64 +: 64];
                end
            end
        end
    end

    always_comb begin
        mem_resp_valid = (state_q == S_RD_BEATS) || (state_q == S_WR_ACK);
        mem_resp_data  = 64'h0;
        mem_resp_id    = id_q;
        if (state_q == S_RD_BEATS) begin
            mem_resp_data = written_q[line_idx][beat_q] ? mem_q[line_idx][beat_q] : pattern;
        end
    end

endmodule
